// File: rtl/wave_ram_bank.sv
// Wave RAM for sound channel 3: two banks of halfword sample storage.
// The playing bank drives addr_0x90..addr_0x9E; CPU writes and reads always
// target the other (idle) bank. NR30 selects the bank directly, and in
// 64-sample mode the banks swap on every pattern wrap.
// Optional readback of the idle bank is enabled with WAVE_RAM_READBACK_EN;
// without it bus_rdata is constant zero and bus_re is ignored.
// The eight addr_0x9X outputs assume HW_PER_BANK == 8.
module wave_ram_bank #(
    parameter int unsigned HW_PER_BANK = 8,
    parameter logic [15:0] RESET_FILL  = 16'h0
) (
    input  logic                           system_clock,
    input  logic                           reset,
    input  logic                           bus_we,
    input  logic                           bus_re,
    input  logic [$clog2(HW_PER_BANK)-1:0] bus_addr,
    input  logic [1:0]                     bus_be,
    input  logic [15:0]                    bus_wdata,
    output logic [15:0]                    bus_rdata,
    input  logic [7:0]                     NR30,
    input  logic                           nr30_we,
    input  logic                           pattern_wrap,
    output logic [15:0]                    addr_0x90,
    output logic [15:0]                    addr_0x92,
    output logic [15:0]                    addr_0x94,
    output logic [15:0]                    addr_0x96,
    output logic [15:0]                    addr_0x98,
    output logic [15:0]                    addr_0x9A,
    output logic [15:0]                    addr_0x9C,
    output logic [15:0]                    addr_0x9E,
    output logic                           play_bank
);

    logic        nr30_play_en;
    logic        nr30_bank_sel;
    logic        nr30_dim64;
    logic [4:0]  unused_nr30;

    logic        play_bank_q;
    logic        play_bank_d;
    logic        idle_bank;

    logic [15:0] ram_q [2][HW_PER_BANK];
    logic [15:0] ram_d [2][HW_PER_BANK];

    assign nr30_play_en  = NR30[7];
    assign nr30_bank_sel = NR30[6];
    assign nr30_dim64    = NR30[5];
    assign unused_nr30   = NR30[4:0];

    // Idle bank is taken from the pre-edge play bank, so a write that
    // coincides with a swap lands in the bank that was idle this cycle.
    assign idle_bank = ~play_bank_q;

    // Bank selection: disabled channel tracks NR30, an NR30 write beats a wrap,
    // and a wrap only swaps in 64-sample mode.
    always_comb begin
        play_bank_d = play_bank_q;
        if (!nr30_play_en) begin
            play_bank_d = nr30_bank_sel;
        end else if (nr30_we) begin
            play_bank_d = nr30_bank_sel;
        end else if (pattern_wrap && nr30_dim64) begin
            play_bank_d = ~play_bank_q;
        end
    end

    // Byte-masked write into the idle bank; the playing bank is never touched.
    always_comb begin
        ram_d = ram_q;
        if (bus_we) begin
            if (bus_be[0]) begin
                ram_d[idle_bank][bus_addr][7:0] = bus_wdata[7:0];
            end
            if (bus_be[1]) begin
                ram_d[idle_bank][bus_addr][15:8] = bus_wdata[15:8];
            end
        end
    end

    // Play bank register.
    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            play_bank_q <= 1'b0;
        end else begin
            play_bank_q <= play_bank_d;
        end
    end

    // Sample storage, both banks preloaded with RESET_FILL.
    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < int'(HW_PER_BANK); i++) begin
                    ram_q[b][i] <= RESET_FILL;
                end
            end
        end else begin
            ram_q <= ram_d;
        end
    end

`ifdef WAVE_RAM_READBACK_EN
    logic [15:0] rdata_q;
    logic [15:0] rdata_d;

    // Readback of the idle bank; sampled from ram_q so a coincident write
    // returns the pre-write contents.
    always_comb begin
        rdata_d = rdata_q;
        if (bus_re) begin
            rdata_d = ram_q[idle_bank][bus_addr];
        end
    end

    // Read data register, holds between reads.
    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            rdata_q <= 16'h0000;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign bus_rdata = rdata_q;
`else
    logic unused_bus_re;

    assign unused_bus_re = bus_re;
    assign bus_rdata     = 16'h0000;
`endif

    assign play_bank = play_bank_q;

    assign addr_0x90 = ram_q[play_bank_q][0];
    assign addr_0x92 = ram_q[play_bank_q][1];
    assign addr_0x94 = ram_q[play_bank_q][2];
    assign addr_0x96 = ram_q[play_bank_q][3];
    assign addr_0x98 = ram_q[play_bank_q][4];
    assign addr_0x9A = ram_q[play_bank_q][5];
    assign addr_0x9C = ram_q[play_bank_q][6];
    assign addr_0x9E = ram_q[play_bank_q][7];

endmodule

// File: tb/tb_wave_ram_bank.sv
// Self-checking bench for wave_ram_bank: directed scenarios followed by
// random traffic, all compared against a bank/array reference model.
module tb_wave_ram_bank;

    logic        system_clock = 1'b0;
    logic        reset;
    logic        bus_we;
    logic        bus_re;
    logic [2:0]  bus_addr;
    logic [1:0]  bus_be;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata;
    logic [7:0]  NR30;
    logic        nr30_we;
    logic        pattern_wrap;
    logic [15:0] a90, a92, a94, a96, a98, a9a, a9c, a9e;
    logic        play_bank;

    logic [15:0] hw_obs [8];

    // Reference model state
    logic [15:0] m_ram [2][8];
    logic        m_play;
    logic [15:0] m_rdata;

    int errors = 0;
    int checks = 0;

    wave_ram_bank dut (
        .system_clock (system_clock),
        .reset        (reset),
        .bus_we       (bus_we),
        .bus_re       (bus_re),
        .bus_addr     (bus_addr),
        .bus_be       (bus_be),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata),
        .NR30         (NR30),
        .nr30_we      (nr30_we),
        .pattern_wrap (pattern_wrap),
        .addr_0x90    (a90),
        .addr_0x92    (a92),
        .addr_0x94    (a94),
        .addr_0x96    (a96),
        .addr_0x98    (a98),
        .addr_0x9A    (a9a),
        .addr_0x9C    (a9c),
        .addr_0x9E    (a9e),
        .play_bank    (play_bank)
    );

    assign hw_obs[0] = a90;
    assign hw_obs[1] = a92;
    assign hw_obs[2] = a94;
    assign hw_obs[3] = a96;
    assign hw_obs[4] = a98;
    assign hw_obs[5] = a9a;
    assign hw_obs[6] = a9c;
    assign hw_obs[7] = a9e;

    always #5 system_clock = ~system_clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 8; i++)
                m_ram[b][i] = 16'h0000;
        m_play  = 1'b0;
        m_rdata = 16'h0000;
    endtask

    // One clock edge of the reference behaviour, from the inputs held at the edge.
    task automatic model_edge();
        int ib;
        ib = m_play ? 0 : 1;
`ifdef WAVE_RAM_READBACK_EN
        if (bus_re) m_rdata = m_ram[ib][bus_addr];
`endif
        if (bus_we) begin
            if (bus_be[0]) m_ram[ib][bus_addr][7:0]  = bus_wdata[7:0];
            if (bus_be[1]) m_ram[ib][bus_addr][15:8] = bus_wdata[15:8];
        end
        if (!NR30[7])                    m_play = NR30[6];
        else if (nr30_we)                m_play = NR30[6];
        else if (pattern_wrap && NR30[5]) m_play = !m_play;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".play_bank"}, {15'b0, play_bank}, {15'b0, m_play});
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s.hw%0d", tag, i), hw_obs[i], m_ram[m_play][i]);
        chk({tag, ".rdata"}, bus_rdata, m_rdata);
    endtask

    task automatic tick(input string tag);
        @(posedge system_clock);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic clear_pulses();
        bus_we       = 1'b0;
        bus_re       = 1'b0;
        nr30_we      = 1'b0;
        pattern_wrap = 1'b0;
    endtask

    task automatic wr(input logic [2:0] idx, input logic [15:0] data, input logic [1:0] be,
                      input string tag);
        bus_we    = 1'b1;
        bus_addr  = idx;
        bus_wdata = data;
        bus_be    = be;
        tick(tag);
        bus_we = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        bus_addr     = 3'd0;
        bus_be       = 2'b00;
        bus_wdata    = 16'h0000;
        NR30         = 8'h00;
        clear_pulses();
        model_reset();
        #12;
        check_all("reset");
        @(negedge system_clock);
        reset = 1'b0;

        // 1: writes go to bank 1 while bank 0 plays
        wr(3'd0, 16'h1234, 2'b11, "t1.w90");
        wr(3'd7, 16'hABCD, 2'b11, "t1.w9e");
        NR30 = 8'h80;
        tick("t1.en");
        chk("t1.play", {15'b0, play_bank}, 16'h0000);
        chk("t1.a90", a90, 16'h0000);
        chk("t1.a9e", a9e, 16'h0000);

        // 2: NR30 write selects bank 1
        NR30    = 8'hC0;
        nr30_we = 1'b1;
        tick("t2.sel");
        nr30_we = 1'b0;
        chk("t2.play", {15'b0, play_bank}, 16'h0001);
        chk("t2.a90", a90, 16'h1234);
        chk("t2.a9e", a9e, 16'hABCD);

        // 3: 64-sample mode swaps on every wrap; 32-sample mode does not
        NR30    = 8'hA0;
        nr30_we = 1'b1;
        tick("t3.sel0");
        nr30_we = 1'b0;
        chk("t3.play0", {15'b0, play_bank}, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            pattern_wrap = 1'b1;
            tick($sformatf("t3.wrap%0d", k));
            pattern_wrap = 1'b0;
            chk($sformatf("t3.toggle%0d", k), {15'b0, play_bank}, (k % 2 == 0) ? 16'h1 : 16'h0);
        end
        NR30 = 8'h80;
        for (int k = 0; k < 2; k++) begin
            pattern_wrap = 1'b1;
            tick($sformatf("t3.hold%0d", k));
            pattern_wrap = 1'b0;
            chk($sformatf("t3.held%0d", k), {15'b0, play_bank}, 16'h0001);
        end

        // 4: byte enables on idle bank 0, then expose it
        wr(3'd3, 16'h5678, 2'b11, "t4.full");
        wr(3'd3, 16'hFFFF, 2'b01, "t4.lo");
        wr(3'd3, 16'h1100, 2'b10, "t4.hi");
        wr(3'd3, 16'hDEAD, 2'b00, "t4.none");
        NR30    = 8'h80;
        nr30_we = 1'b1;
        tick("t4.show");
        nr30_we = 1'b0;
        chk("t4.a96", a96, 16'h11FF);

        // 5: write coincident with a wrap swap lands in the old idle bank
        NR30         = 8'hA0;
        pattern_wrap = 1'b1;
        bus_we       = 1'b1;
        bus_addr     = 3'd2;
        bus_wdata    = 16'h00AA;
        bus_be       = 2'b11;
        tick("t5.swap");
        clear_pulses();
        chk("t5.play", {15'b0, play_bank}, 16'h0001);
        chk("t5.a94", a94, 16'h00AA);

        // 6: readback of the idle bank, simultaneous write returns old data
        NR30 = 8'h80;
        wr(3'd2, 16'h00AA, 2'b11, "t6.w");
        bus_re   = 1'b1;
        bus_addr = 3'd2;
        tick("t6.re");
`ifdef WAVE_RAM_READBACK_EN
        chk("t6.rdata", bus_rdata, 16'h00AA);
`else
        chk("t6.rdata", bus_rdata, 16'h0000);
`endif
        bus_we    = 1'b1;
        bus_wdata = 16'h7777;
        tick("t6.rw");
        clear_pulses();
`ifdef WAVE_RAM_READBACK_EN
        chk("t6.rw_old", bus_rdata, 16'h00AA);
`else
        chk("t6.rw_old", bus_rdata, 16'h0000);
`endif

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            bus_we       = 1'($urandom_range(0, 1));
            bus_re       = 1'($urandom_range(0, 1));
            bus_addr     = 3'($urandom_range(0, 7));
            bus_be       = 2'($urandom_range(0, 3));
            bus_wdata    = 16'($urandom);
            NR30         = 8'($urandom);
            if ($urandom_range(0, 3) != 0) NR30[7] = 1'b1;
            nr30_we      = ($urandom_range(0, 7) == 0);
            pattern_wrap = ($urandom_range(0, 3) == 0);
            tick($sformatf("rnd%0d", n));
        end
        clear_pulses();

        // Asynchronous reset in the middle of a write
        NR30      = 8'hC0;
        bus_we    = 1'b1;
        bus_addr  = 3'd5;
        bus_wdata = 16'hBEEF;
        bus_be    = 2'b11;
        @(negedge system_clock);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        chk("async_rst.a9a", a9a, 16'h0000);
        @(negedge system_clock);
        clear_pulses();
        reset = 1'b0;
        NR30  = 8'h00;
        tick("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
